// File: rtl/serial_to_parallel.sv
// Reassembles a UART byte stream into N-bit words, least-significant byte first,
// and holds each completed word behind a valid/ready handshake for the consumer.
module serial_to_parallel #(
    parameter int N       = 16,
    parameter int CNT_W   = 2,
    parameter int TIMEOUT = 1000000,
    parameter int TO_W    = 20
) (
    input  logic         iCE_CLK,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    input  logic         word_ready,
    output logic         word_valid,
    output logic [N-1:0] word,
    output logic         overrun,
    output logic         timeout_err
);

    localparam int NBYTES = N / 8;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic {
        EMPTY,
        PARTIAL
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [N-1:0]     r_shift;
    logic [TO_W-1:0]  r_toCnt;

    logic [N-1:0]     w_assembled;
    logic             w_complete;
    logic             w_expire;

    // Current assembly register with the incoming byte dropped into its lane.
    always_comb begin
        w_assembled = r_shift;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_count == CNT_W'(i)) begin
                w_assembled[8*i +: 8] = rx_byte;
            end
        end
    end

    assign w_complete = rx_valid && (r_count == LAST_LANE);
    assign w_expire   = (r_state == PARTIAL) && !rx_valid && (r_toCnt == TO_LAST);

    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_count     <= '0;
            r_shift     <= '0;
            r_toCnt     <= '0;
            word_valid  <= 1'b0;
            word        <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;

            if (rx_valid) begin
                r_toCnt <= '0;
                if (w_complete) begin
                    r_count <= '0;
                    r_shift <= '0;
                    r_state <= EMPTY;
                end else begin
                    r_count <= r_count + 1'b1;
                    r_shift <= w_assembled;
                    r_state <= PARTIAL;
                end
            end else if (r_state == PARTIAL) begin
                // A lost byte would otherwise shift every later word by one lane.
                if (w_expire) begin
                    r_count     <= '0;
                    r_shift     <= '0;
                    r_toCnt     <= '0;
                    r_state     <= EMPTY;
                    timeout_err <= 1'b1;
                end else begin
                    r_toCnt <= r_toCnt + 1'b1;
                end
            end else begin
                r_toCnt <= '0;
            end

            // Output holding register runs independently of the assembly side.
            if (w_complete && (!word_valid || word_ready)) begin
                word       <= w_assembled;
                word_valid <= 1'b1;
            end else begin
                if (w_complete) begin
                    overrun <= 1'b1;
                end
                if (word_valid && word_ready) begin
                    word_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel: a 16-bit build with a short timeout
// and a 32-bit build, sharing one clock and reset.
module tb_serial_to_parallel;

    logic        clk;
    logic        rst_n;

    logic        rxValid16, ready16, valid16, overrun16, toErr16;
    logic [7:0]  rxByte16;
    logic [15:0] word16;

    logic        rxValid32, ready32, valid32, overrun32, toErr32;
    logic [7:0]  rxByte32;
    logic [31:0] word32;

    int          checkCount = 0;
    int          passCount  = 0;
    int          toSeen16   = 0;
    int          toSeen32   = 0;
    logic [31:0] exp16[$];
    logic [31:0] exp32[$];

    serial_to_parallel #(.N(16), .CNT_W(2), .TIMEOUT(8), .TO_W(4)) dut16 (
        .iCE_CLK(clk), .rst_n(rst_n), .rx_valid(rxValid16), .rx_byte(rxByte16),
        .word_ready(ready16), .word_valid(valid16), .word(word16),
        .overrun(overrun16), .timeout_err(toErr16)
    );

    serial_to_parallel #(.N(32), .CNT_W(3), .TIMEOUT(8), .TO_W(4)) dut32 (
        .iCE_CLK(clk), .rst_n(rst_n), .rx_valid(rxValid32), .rx_byte(rxByte32),
        .word_ready(ready32), .word_valid(valid32), .word(word32),
        .overrun(overrun32), .timeout_err(toErr32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Strobes one byte; returns just after the edge that sampled it.
    task automatic applyStimulus(input bit sel32, input logic [7:0] b);
        if (sel32) begin
            rxValid32 = 1'b1;
            rxByte32  = b;
        end else begin
            rxValid16 = 1'b1;
            rxByte16  = b;
        end
        @(posedge clk);
        #1;
        rxValid16 = 1'b0;
        rxValid32 = 1'b0;
        rxByte16  = 8'hxx;
        rxByte32  = 8'hxx;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetAll();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    // Monitors: pop the scoreboard on every accepted word.
    always @(negedge clk) begin
        if (rst_n && valid16 && ready16) begin
            if (exp16.size() == 0) begin
                checkOutput("sb16 unexpected word", {16'h0, word16}, 32'hDEADDEAD);
            end else begin
                checkOutput("sb16 word", {16'h0, word16}, exp16.pop_front());
            end
        end
        if (rst_n && valid32 && ready32) begin
            if (exp32.size() == 0) begin
                checkOutput("sb32 unexpected word", word32, 32'hDEADDEAD);
            end else begin
                checkOutput("sb32 word", word32, exp32.pop_front());
            end
        end
        if (rst_n && toErr16) toSeen16++;
        if (rst_n && toErr32) toSeen32++;
    end

    initial begin
        int toBefore;
        rst_n     = 1'b1;
        rxValid16 = 1'b0;
        rxValid32 = 1'b0;
        rxByte16  = 8'h00;
        rxByte32  = 8'h00;
        ready16   = 1'b1;
        ready32   = 1'b1;
        #1;
        rst_n = 1'b0;
        idle(2);
        checkOutput("reset valid16", {31'h0, valid16}, 32'h0);
        checkOutput("reset word16", {16'h0, word16}, 32'h0);
        checkOutput("reset overrun16", {31'h0, overrun16}, 32'h0);
        checkOutput("reset timeout16", {31'h0, toErr16}, 32'h0);
        checkOutput("reset valid32", {31'h0, valid32}, 32'h0);
        checkOutput("reset word32", word32, 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Basic assembly with gaps between bytes.
        exp16.push_back(32'h1234);
        applyStimulus(0, 8'h34);
        idle(3);
        checkOutput("basic valid before last byte", {31'h0, valid16}, 32'h0);
        applyStimulus(0, 8'h12);
        checkOutput("basic valid latency", {31'h0, valid16}, 32'h1);
        checkOutput("basic word", {16'h0, word16}, 32'h1234);
        idle(1);
        checkOutput("basic valid one cycle", {31'h0, valid16}, 32'h0);
        checkOutput("basic overrun", {31'h0, overrun16}, 32'h0);

        // Back-pressure and overrun.
        ready16 = 1'b0;
        exp16.push_back(32'hABCD);
        applyStimulus(0, 8'hCD);
        applyStimulus(0, 8'hAB);
        idle(2);
        checkOutput("bp valid held", {31'h0, valid16}, 32'h1);
        checkOutput("bp word held", {16'h0, word16}, 32'hABCD);
        applyStimulus(0, 8'h01);
        applyStimulus(0, 8'h02);
        checkOutput("bp overrun set", {31'h0, overrun16}, 32'h1);
        checkOutput("bp word kept", {16'h0, word16}, 32'hABCD);
        ready16 = 1'b1;
        idle(1);
        checkOutput("bp valid falls", {31'h0, valid16}, 32'h0);
        checkOutput("bp overrun sticky", {31'h0, overrun16}, 32'h1);
        resetAll();
        checkOutput("overrun cleared by reset", {31'h0, overrun16}, 32'h0);

        // New word completes in the same cycle the held word is accepted.
        ready16 = 1'b0;
        exp16.push_back(32'h1111);
        applyStimulus(0, 8'h11);
        applyStimulus(0, 8'h11);
        applyStimulus(0, 8'h22);
        ready16 = 1'b1;
        exp16.push_back(32'h2222);
        applyStimulus(0, 8'h22);
        checkOutput("simul valid", {31'h0, valid16}, 32'h1);
        checkOutput("simul word", {16'h0, word16}, 32'h2222);
        checkOutput("simul overrun", {31'h0, overrun16}, 32'h0);
        idle(1);
        checkOutput("simul valid falls", {31'h0, valid16}, 32'h0);

        // A byte on the last idle cycle beats the timeout.
        exp16.push_back(32'h6655);
        applyStimulus(0, 8'h55);
        idle(7);
        applyStimulus(0, 8'h66);
        checkOutput("rx wins timeout", {31'h0, toErr16}, 32'h0);
        checkOutput("rx wins word", {16'h0, word16}, 32'h6655);

        // Partial word expires after eight idle cycles.
        applyStimulus(0, 8'h55);
        idle(7);
        checkOutput("timeout not early", {31'h0, toErr16}, 32'h0);
        idle(1);
        checkOutput("timeout pulse", {31'h0, toErr16}, 32'h1);
        checkOutput("timeout no valid", {31'h0, valid16}, 32'h0);
        idle(1);
        checkOutput("timeout one cycle", {31'h0, toErr16}, 32'h0);
        checkOutput("timeout pulse count", toSeen16, 32'd1);
        exp16.push_back(32'h5678);
        applyStimulus(0, 8'h78);
        applyStimulus(0, 8'h56);
        checkOutput("after timeout word", {16'h0, word16}, 32'h5678);
        idle(1);

        // Asynchronous reset mid-word with a word held at the output.
        ready16 = 1'b0;
        applyStimulus(0, 8'h21);
        applyStimulus(0, 8'h43);
        applyStimulus(0, 8'h99);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset valid", {31'h0, valid16}, 32'h0);
        checkOutput("async reset word", {16'h0, word16}, 32'h0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ready16 = 1'b1;
        toBefore = toSeen16;
        exp16.push_back(32'hBEEF);
        applyStimulus(0, 8'hEF);
        applyStimulus(0, 8'hBE);
        checkOutput("post reset word", {16'h0, word16}, 32'hBEEF);
        idle(12);
        checkOutput("post reset no timeout", toSeen16, toBefore);

        // 32-bit build, back-to-back bytes.
        exp32.push_back(32'h01020304);
        applyStimulus(1, 8'h04);
        applyStimulus(1, 8'h03);
        applyStimulus(1, 8'h02);
        checkOutput("n32 not early", {31'h0, valid32}, 32'h0);
        applyStimulus(1, 8'h01);
        checkOutput("n32 valid latency", {31'h0, valid32}, 32'h1);
        checkOutput("n32 word", word32, 32'h01020304);
        idle(2);
        checkOutput("n32 valid falls", {31'h0, valid32}, 32'h0);
        checkOutput("n32 no timeout", toSeen32, 32'd0);

        checkOutput("sb16 drained", exp16.size(), 32'd0);
        checkOutput("sb32 drained", exp32.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
